// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-core data memory: default sizes and
// byte-address decode helpers used by the arbiter top.
package dmem_pkg;

  localparam int DEF_NUM_CORES = 2;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 32;

  // Helpers take a 64-bit zero-extended address so any DATA_W up to 64 fits.
  localparam int ADDR_MAX_W = 64;

  function automatic logic [ADDR_MAX_W-1:0] word_index(input logic [ADDR_MAX_W-1:0] addr,
                                                       input int aw);
    logic [ADDR_MAX_W-1:0] mask;
    mask = (64'd1 << aw) - 64'd1;
    return (addr >> 2) & mask;
  endfunction

  function automatic logic addr_in_range(input logic [ADDR_MAX_W-1:0] addr,
                                         input int aw);
    return (addr >> (aw + 2)) == '0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after rr_ptr
// (wrapping modulo NUM_CORES) wins.
module rr_arbiter #(
  parameter int NUM_CORES = 2
) (
  input  logic [NUM_CORES-1:0]         req_i,
  input  logic [$clog2(NUM_CORES)-1:0] rr_ptr_i,
  output logic [NUM_CORES-1:0]         grant_o,
  output logic [$clog2(NUM_CORES)-1:0] grant_idx_o,
  output logic                         any_grant_o
);

  localparam int PW = $clog2(NUM_CORES);

  int w_idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    w_idx       = 0;
    for (int off = NUM_CORES - 1; off >= 0; off--) begin
      w_idx = (int'(rr_ptr_i) + off) % NUM_CORES;
      if (req_i[w_idx]) begin
        grant_o        = '0;
        grant_o[w_idx] = 1'b1;
        grant_idx_o    = PW'(w_idx);
        any_grant_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_dmem_arbiter.sv
// NUM_CORES-port word-addressed data memory with a round-robin arbiter;
// one access per cycle, responses registered one cycle after the grant.
module shared_dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CORES-1:0]          req_valid_i,
  input  logic [NUM_CORES-1:0]          req_write_i,
  input  logic [NUM_CORES*DATA_W-1:0]   req_addr_i,
  input  logic [NUM_CORES*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_CORES-1:0]          req_ready_o,
  output logic [NUM_CORES-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]             rsp_rdata_o,
  output logic                          err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(NUM_CORES);

  logic [PW-1:0]        r_rr_ptr;
  logic [NUM_CORES-1:0] r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_rdata;
  logic                 r_err;
  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic [NUM_CORES-1:0] w_req;
  logic [NUM_CORES-1:0] w_grant;
  logic [PW-1:0]        w_grant_idx;
  logic                 w_any_grant;
  logic [DATA_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;
  logic                 w_sel_write;
  logic                 w_in_range;
  logic [AW-1:0]        w_word_idx;
  logic [PW-1:0]        w_next_ptr;

  // No grant may be issued while reset is held.
  assign w_req = rst_i ? '0 : req_valid_i;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_rr_arbiter (
    .req_i       (w_req),
    .rr_ptr_i    (r_rr_ptr),
    .grant_o     (w_grant),
    .grant_idx_o (w_grant_idx),
    .any_grant_o (w_any_grant)
  );

  always_comb begin
    w_sel_addr  = req_addr_i[int'(w_grant_idx)*DATA_W +: DATA_W];
    w_sel_wdata = req_wdata_i[int'(w_grant_idx)*DATA_W +: DATA_W];
    w_sel_write = req_write_i[w_grant_idx];
    w_in_range  = addr_in_range(ADDR_MAX_W'(w_sel_addr), AW);
    w_word_idx  = AW'(word_index(ADDR_MAX_W'(w_sel_addr), AW));
    w_next_ptr  = (w_grant_idx == PW'(NUM_CORES - 1)) ? '0 : w_grant_idx + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_rsp_valid <= w_any_grant ? w_grant : '0;
      if (w_any_grant) begin
        r_rr_ptr <= w_next_ptr;
        if (!w_in_range) begin
          r_err <= 1'b1;
        end
        // Writes acknowledge with zero data; out-of-range reads also return zero.
        if (w_sel_write) begin
          r_rsp_rdata <= '0;
          if (w_in_range) begin
            r_mem[w_word_idx] <= w_sel_wdata;
          end
        end else begin
          r_rsp_rdata <= w_in_range ? r_mem[w_word_idx] : '0;
        end
      end
    end
  end

  assign req_ready_o = w_grant;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign err_o       = r_err;

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Directed bench for shared_dmem_arbiter: a 4-core instance for most scenarios
// and a 2-core instance for the collision case.
module tb_shared_dmem_arbiter;

  logic clk;
  logic rst;

  logic [3:0]   v4, w4, rdy4, rspv4;
  logic [127:0] a4, wd4;
  logic [31:0]  rd4;
  logic         err4;

  logic [1:0]   v2, w2, rdy2, rspv2;
  logic [63:0]  a2, wd2;
  logic [31:0]  rd2;
  logic         err2;

  int total;
  int bad;

  shared_dmem_arbiter #(.NUM_CORES(4), .DATA_W(32), .DEPTH(32)) u_dut4 (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (v4),
    .req_write_i (w4),
    .req_addr_i  (a4),
    .req_wdata_i (wd4),
    .req_ready_o (rdy4),
    .rsp_valid_o (rspv4),
    .rsp_rdata_o (rd4),
    .err_o       (err4)
  );

  shared_dmem_arbiter #(.NUM_CORES(2), .DATA_W(32), .DEPTH(32)) u_dut2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (v2),
    .req_write_i (w2),
    .req_addr_i  (a2),
    .req_wdata_i (wd2),
    .req_ready_o (rdy2),
    .rsp_valid_o (rspv2),
    .rsp_rdata_o (rd2),
    .err_o       (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v4 = 4'b1111; w4 = '0; a4 = '0; wd4 = '0;
    v2 = 2'b00;   w2 = '0; a2 = '0; wd2 = '0;
    #1;
    total++;
    if (rdy4 !== 4'b0000) begin
      bad++; $display("FAIL reset_ready got=%b exp=0000", rdy4);
    end
    step();
    step();
    rst = 1'b0;
    v4 = 4'b0000;
    total++;
    if (rspv4 !== 4'b0000) begin
      bad++; $display("FAIL reset_rspv got=%b exp=0000", rspv4);
    end
    total++;
    if (rd4 !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=00000000", rd4);
    end
    total++;
    if (err4 !== 1'b0 || err2 !== 1'b0) begin
      bad++; $display("FAIL reset_err got=%b%b exp=00", err4, err2);
    end
    $display("test_reset: done");
  endtask

  task automatic test_write_read();
    v4 = 4'b0001; w4 = 4'b0001; a4[31:0] = 32'h8; wd4[31:0] = 32'h1234;
    #1;
    total++;
    if (rdy4 !== 4'b0001) begin
      bad++; $display("FAIL wr_ready got=%b exp=0001", rdy4);
    end
    step();
    total++;
    if (rspv4 !== 4'b0001 || rd4 !== 32'h0) begin
      bad++; $display("FAIL wr_ack got=%b/%h exp=0001/00000000", rspv4, rd4);
    end
    w4 = 4'b0000;
    #1;
    step();
    total++;
    if (rspv4 !== 4'b0001 || rd4 !== 32'h1234) begin
      bad++; $display("FAIL rd_data got=%b/%h exp=0001/00001234", rspv4, rd4);
    end
    v4 = 4'b0000;
    $display("test_write_read: rdata=%h", rd4);
  endtask

  task automatic test_race();
    v4 = 4'b0010; w4 = 4'b0010; a4[63:32] = 32'h10; wd4[63:32] = 32'hAA;
    #1;
    total++;
    if (rdy4 !== 4'b0010) begin
      bad++; $display("FAIL race_wr_ready got=%b exp=0010", rdy4);
    end
    step();
    v4 = 4'b0001; w4 = 4'b0000; a4[31:0] = 32'h10;
    total++;
    if (rspv4 !== 4'b0010) begin
      bad++; $display("FAIL race_wr_ack got=%b exp=0010", rspv4);
    end
    #1;
    step();
    total++;
    if (rspv4 !== 4'b0001 || rd4 !== 32'hAA) begin
      bad++; $display("FAIL race_rd got=%b/%h exp=0001/000000aa", rspv4, rd4);
    end
    v4 = 4'b0000;
    $display("test_race: rdata=%h", rd4);
  endtask

  task automatic test_collision();
    v2 = 2'b11; w2 = 2'b00; a2 = '0;
    #1;
    total++;
    if (rdy2 !== 2'b01) begin
      bad++; $display("FAIL coll_t_ready got=%b exp=01", rdy2);
    end
    step();
    v2 = 2'b10;
    total++;
    if (rspv2 !== 2'b01) begin
      bad++; $display("FAIL coll_t_rsp got=%b exp=01", rspv2);
    end
    #1;
    total++;
    if (rdy2 !== 2'b10) begin
      bad++; $display("FAIL coll_t1_ready got=%b exp=10", rdy2);
    end
    step();
    total++;
    if (rspv2 !== 2'b10 || rd2 !== 32'h0) begin
      bad++; $display("FAIL coll_t1_rsp got=%b/%h exp=10/00000000", rspv2, rd2);
    end
    // Pointer back at 0: core 0 wins a fresh tie.
    v2 = 2'b11;
    #1;
    total++;
    if (rdy2 !== 2'b01) begin
      bad++; $display("FAIL coll_ptr got=%b exp=01", rdy2);
    end
    v2 = 2'b00;
    $display("test_collision: done");
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    rst = 1'b1;
    step();
    rst = 1'b0;
    v4 = 4'b1111; w4 = 4'b0000; a4 = '0;
    #1;
    for (int c = 0; c < 8; c++) begin
      exp_g = 4'b0001 << (c % 4);
      total++;
      if (rdy4 !== exp_g) begin
        bad++; $display("FAIL fair_grant%0d got=%b exp=%b", c, rdy4, exp_g);
      end
      step();
      total++;
      if (rspv4 !== exp_g) begin
        bad++; $display("FAIL fair_rsp%0d got=%b exp=%b", c, rspv4, exp_g);
      end
      $display("test_fairness: cycle %0d grant=%b", c, exp_g);
    end
    v4 = 4'b0000;
  endtask

  task automatic test_out_of_range();
    v4 = 4'b0001; w4 = 4'b0001; a4[31:0] = 32'h0; wd4[31:0] = 32'hCAFE;
    #1;
    total++;
    if (rdy4 !== 4'b0001) begin
      bad++; $display("FAIL oor_pre_ready got=%b exp=0001", rdy4);
    end
    step();
    total++;
    if (err4 !== 1'b0) begin
      bad++; $display("FAIL oor_err_before got=%b exp=0", err4);
    end
    a4[31:0] = 32'h80; wd4[31:0] = 32'hDEAD;
    #1;
    step();
    total++;
    if (err4 !== 1'b1 || rspv4 !== 4'b0001 || rd4 !== 32'h0) begin
      bad++; $display("FAIL oor_wr got=%b/%b/%h exp=1/0001/00000000", err4, rspv4, rd4);
    end
    w4 = 4'b0000;
    #1;
    step();
    total++;
    if (rd4 !== 32'h0 || err4 !== 1'b1) begin
      bad++; $display("FAIL oor_rd got=%h/%b exp=00000000/1", rd4, err4);
    end
    a4[31:0] = 32'h0;
    #1;
    step();
    total++;
    if (rd4 !== 32'hCAFE) begin
      bad++; $display("FAIL oor_mem_intact got=%h exp=0000cafe", rd4);
    end
    v4 = 4'b0000;
    $display("test_out_of_range: err=%b", err4);
  endtask

  task automatic test_reset_midstream();
    v4 = 4'b0001; w4 = 4'b0001; a4[31:0] = 32'h8; wd4[31:0] = 32'h77;
    #1;
    step();
    v4 = 4'b0011; w4 = 4'b0000; a4[31:0] = 32'h8; a4[63:32] = 32'h8;
    rst = 1'b1;
    #1;
    total++;
    if (rdy4 !== 4'b0000) begin
      bad++; $display("FAIL mid_ready_in_rst got=%b exp=0000", rdy4);
    end
    step();
    rst = 1'b0;
    total++;
    if (rspv4 !== 4'b0000) begin
      bad++; $display("FAIL mid_rspv got=%b exp=0000", rspv4);
    end
    total++;
    if (err4 !== 1'b0) begin
      bad++; $display("FAIL mid_err got=%b exp=0", err4);
    end
    #1;
    total++;
    if (rdy4 !== 4'b0001) begin
      bad++; $display("FAIL mid_ptr got=%b exp=0001", rdy4);
    end
    step();
    total++;
    if (rspv4 !== 4'b0001 || rd4 !== 32'h0) begin
      bad++; $display("FAIL mid_mem_cleared got=%b/%h exp=0001/00000000", rspv4, rd4);
    end
    v4 = 4'b0000;
    $display("test_reset_midstream: rdata=%h", rd4);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_race();
    test_collision();
    test_fairness();
    test_out_of_range();
    test_reset_midstream();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
